// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Covers load-use bubbles, Mem-stage branch flushes and multi-cycle data memory waits.
module pipeline_hazard_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       DecRn,
    input  logic [4:0]       DecRm,
    input  logic             DecUseRn,
    input  logic             DecUseRm,
    input  logic             ExValid,
    input  logic             ExMemRead,
    input  logic [4:0]       ExRd,
    input  logic             MemBrTaken,
    input  logic             MemReq,
    input  logic             MemAck,
    input  logic             WbValid,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXWrite,
    output logic             EXMEMWrite,
    output logic             MEMWBWrite,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             EXMEMFlush,
    output logic [1:0]       CtrlState,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount,
    output logic [CNT_W-1:0] RetireCount
);
    typedef enum logic [1:0] {RUN = 2'b00, LOAD_BUBBLE = 2'b01, MEM_WAIT = 2'b10} state_t;
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic          lu, in_mem, br, miss, stall_lu, timeout, hold, frozen;

    assign lu = ExValid & ExMemRead & (ExRd != 5'd31) &
                ((DecUseRn & (DecRn == ExRd)) | (DecUseRm & (DecRm == ExRd)));
    assign in_mem   = reset & (state == MEM_WAIT);
    assign br       = reset & !in_mem & MemBrTaken;
    assign miss     = reset & !in_mem & !MemBrTaken & MemReq & !MemAck;
    assign stall_lu = reset & (state == RUN) & !MemBrTaken & !miss & lu;
    assign timeout  = in_mem & !MemAck & (wait_cnt >= WW'(MEM_TIMEOUT));
    assign hold     = in_mem & !MemAck & !timeout;
    assign frozen   = miss | hold;

    assign PCWrite    = !(frozen | stall_lu);
    assign IFIDWrite  = !(frozen | stall_lu);
    assign IDEXWrite  = !frozen;
    assign EXMEMWrite = !frozen;
    assign MEMWBWrite = !frozen;
    assign IFIDFlush  = br;
    assign IDEXFlush  = br | stall_lu;
    assign EXMEMFlush = br;
    assign CtrlState  = state;

    // Saturating increment: the carry is suppressed once every bit is set.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return v + CNT_W'(en & ~&v);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            MemTimeout  <= 1'b0;
            StallCount  <= '0;
            FlushCount  <= '0;
            RetireCount <= '0;
        end else begin
            state       <= miss ? MEM_WAIT : stall_lu ? LOAD_BUBBLE : hold ? MEM_WAIT : RUN;
            wait_cnt    <= miss ? WW'(1) : hold ? wait_cnt + WW'(1) : wait_cnt;
            MemTimeout  <= MemTimeout | timeout;
            StallCount  <= sat_inc(StallCount, !PCWrite);
            FlushCount  <= sat_inc(FlushCount, br);
            RetireCount <= sat_inc(RetireCount, WbValid);
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed test-plan scenarios then randomized traffic,
// all checked against a cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;
    localparam int CW   = 6;
    localparam int TO   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 0, reset = 0;
    logic [4:0] DecRn, DecRm, ExRd;
    logic DecUseRn, DecUseRm, ExValid, ExMemRead, MemBrTaken, MemReq, MemAck, WbValid;
    logic PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite;
    logic IFIDFlush, IDEXFlush, EXMEMFlush, MemTimeout;
    logic [1:0] CtrlState;
    logic [CW-1:0] StallCount, FlushCount, RetireCount;

    pipeline_hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .DecRn(DecRn), .DecRm(DecRm), .DecUseRn(DecUseRn),
        .DecUseRm(DecUseRm), .ExValid(ExValid), .ExMemRead(ExMemRead), .ExRd(ExRd),
        .MemBrTaken(MemBrTaken), .MemReq(MemReq), .MemAck(MemAck), .WbValid(WbValid),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
        .EXMEMWrite(EXMEMWrite), .MEMWBWrite(MEMWBWrite), .IFIDFlush(IFIDFlush),
        .IDEXFlush(IDEXFlush), .EXMEMFlush(EXMEMFlush), .CtrlState(CtrlState),
        .MemTimeout(MemTimeout), .StallCount(StallCount), .FlushCount(FlushCount),
        .RetireCount(RetireCount)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    // Model: mode 0 running, 1 bubble, 2 waiting on memory (m_k = wait cycle index).
    int m_mode = 0, m_k = 0, m_stall = 0, m_flush = 0, m_retire = 0;
    bit m_to = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return v >= MAXC ? MAXC : v + 1;
    endfunction

    task automatic clear();
        {DecRn, DecRm, ExRd} = '0;
        {DecUseRn, DecUseRm, ExValid, ExMemRead, MemBrTaken, MemReq, MemAck, WbValid} = '0;
    endtask

    task automatic step();
        bit lu;
        bit [4:0] en;
        bit [2:0] fl;
        int nxt;
        if (!reset) begin
            m_mode = 0; m_k = 0; m_stall = 0; m_flush = 0; m_retire = 0; m_to = 0;
        end
        en = 5'h1f; fl = 3'b000; nxt = 0;
        lu = ExValid && ExMemRead && ExRd != 31 &&
             ((DecUseRn && DecRn == ExRd) || (DecUseRm && DecRm == ExRd));
        if (reset) begin
            if (m_mode == 2) begin
                if (!MemAck && m_k < TO) begin en = 0; nxt = 2; end
            end else if (MemBrTaken) fl = 3'b111;
            else if (MemReq && !MemAck) begin en = 0; nxt = 2; end
            else if (lu && m_mode == 0) begin en = 5'b00111; fl = 3'b010; nxt = 1; end
        end
        @(negedge clk);
        check("enables", {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite}, en);
        check("flushes", {IFIDFlush, IDEXFlush, EXMEMFlush}, fl);
        check("state", CtrlState, m_mode);
        check("timeout", MemTimeout, m_to);
        check("stall_cnt", StallCount, m_stall);
        check("flush_cnt", FlushCount, m_flush);
        check("retire_cnt", RetireCount, m_retire);
        @(posedge clk);
        if (reset) begin
            if (m_mode == 2 && !MemAck && m_k >= TO) m_to = 1;
            if (m_mode != 2 && MemBrTaken) m_flush = sat(m_flush);
            if (!en[4]) m_stall = sat(m_stall);
            if (WbValid) m_retire = sat(m_retire);
            m_k = nxt == 2 ? (m_mode == 2 ? m_k + 1 : 1) : 0;
            m_mode = nxt;
        end
        #1;
    endtask

    initial begin
        clear();
        step();
        reset = 1;
        repeat (5) step();
        check("idle_stall", StallCount, 0);
        // Load-use on Rn
        ExValid = 1; ExMemRead = 1; ExRd = 3; DecUseRn = 1; DecRn = 3;
        step(); clear(); step(); step();
        check("lu_stall", StallCount, 1);
        // XZR never hazards
        ExValid = 1; ExMemRead = 1; ExRd = 31; DecUseRn = 1; DecRn = 31;
        step(); clear(); step();
        check("xzr_stall", StallCount, 1);
        // Multi-cycle access: three wait cycles then ack
        MemReq = 1;
        repeat (4) step();
        MemAck = 1; step(); clear(); step();
        check("mem_stall", StallCount, 5);
        check("mem_state", CtrlState, 0);
        // Branch overrides load-use and memory request
        MemBrTaken = 1; MemReq = 1; ExValid = 1; ExMemRead = 1; ExRd = 7; DecUseRm = 1; DecRm = 7;
        step(); clear();
        check("br_flush", FlushCount, 1);
        check("br_stall", StallCount, 5);
        // Timeout after TO wait cycles
        MemReq = 1;
        repeat (5) step();
        clear();
        check("to_flag", MemTimeout, 1);
        repeat (3) step();
        check("to_sticky", MemTimeout, 1);
        // Randomized traffic with occasional async reset pulses
        for (int i = 0; i < 3000; i++) begin
            ExRd = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
            DecRn = 5'($urandom_range(0, 3)); DecRm = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) DecRn = 5'd31;
            DecUseRn = 1'($urandom); DecUseRm = 1'($urandom);
            ExValid = $urandom_range(0, 3) != 0; ExMemRead = 1'($urandom);
            MemBrTaken = $urandom_range(0, 9) == 0;
            MemReq = $urandom_range(0, 3) == 0;
            MemAck = $urandom_range(0, 9) < 3;
            WbValid = 1'($urandom);
            reset = $urandom_range(0, 199) != 0;
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (Fetch, Dec, Ex, Mem, Wb).
- Produces per-stage write enables for the PC and the four pipeline registers, plus bubble/flush controls.
- Handles load-use hazards, taken branches resolved in Mem, and multi-cycle data-memory accesses.
- Keeps saturating performance counters and a sticky memory-timeout error flag.

Parameters:
CNT_W, 32, width of each performance counter
MEM_TIMEOUT, 64, max cycles in MEM_WAIT before forced exit (must be >= 2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset; asynchronous, active-low (0 = in reset)
DecRn  in  5  Rn field of instruction in Dec
DecRm  in  5  second source register of instruction in Dec (after Reg2Loc mux)
DecUseRn  in  1  Dec instruction reads Rn
DecUseRm  in  1  Dec instruction reads second source
ExValid  in  1  Ex stage holds a real instruction (not a bubble)
ExMemRead  in  1  Ex instruction is a load
ExRd  in  5  destination of Ex instruction
MemBrTaken  in  1  branch resolved taken in Mem this cycle
MemReq  in  1  Mem stage issuing a data-memory access this cycle
MemAck  in  1  data memory completes access this cycle
WbValid  in  1  real instruction retiring in Wb
PCWrite  out  1  PC register enable
IFIDWrite  out  1  Fetch->Dec register enable
IDEXWrite  out  1  Dec->Ex register enable
EXMEMWrite  out  1  Ex->Mem register enable
MEMWBWrite  out  1  Mem->Wb register enable
IFIDFlush  out  1  load NOP into Fetch->Dec
IDEXFlush  out  1  load bubble (all controls 0) into Dec->Ex
EXMEMFlush  out  1  load bubble into Ex->Mem
CtrlState  out  2  00 RUN, 01 LOAD_BUBBLE, 10 MEM_WAIT
MemTimeout  out  1  sticky: MEM_WAIT exceeded MEM_TIMEOUT
StallCount  out  CNT_W  cycles with PCWrite=0
FlushCount  out  CNT_W  taken-branch flush events
RetireCount  out  CNT_W  cycles with WbValid=1

Behaviour:
- Reset (reset=0, asynchronous): state RUN, all counters 0, MemTimeout 0. While in reset all enables 1 and all flushes 0.
- Enable/flush outputs are combinational from the current state and inputs. State, counters and MemTimeout are registered.
- Default outputs: all enables 1, all flushes 0.
- Load-use hazard (LU) = ExValid & ExMemRead & ExRd!=31 & ((DecUseRn & DecRn==ExRd) | (DecUseRm & DecRm==ExRd)). XZR (31) never causes a hazard.
- Evaluation priority each cycle in RUN or LOAD_BUBBLE:
  - 1. MemBrTaken: IFIDFlush=IDEXFlush=EXMEMFlush=1, enables 1 (PC loads branch target); FlushCount++; next RUN. MemReq and LU ignored this cycle.
  - 2. MemReq & !MemAck: all five enables 0; next MEM_WAIT; wait counter cleared to 1.
  - 3. LU and state==RUN: PCWrite=0, IFIDWrite=0, IDEXFlush=1; next LOAD_BUBBLE.
  - 4. Otherwise next RUN. MemReq & MemAck in the same cycle is a single-cycle access and causes no stall.
- LOAD_BUBBLE lasts exactly one cycle. LU is not re-evaluated there, so back-to-back loads produce one bubble per consumer.
- MEM_WAIT:
  - All enables 0, flushes 0; wait counter increments.
  - MemAck=1: enables 1 that cycle, next RUN.
  - Wait counter reaches MEM_TIMEOUT without MemAck: set MemTimeout, enables 1 that cycle, next RUN.
  - MemBrTaken is ignored in MEM_WAIT (Mem is frozen).
- Counters saturate at 2^CNT_W-1 and never wrap. StallCount increments on every clock edge where PCWrite was 0. RetireCount increments on WbValid regardless of stalls.
- Reset asserted mid-MEM_WAIT or mid-LOAD_BUBBLE: immediate return to RUN, counters 0.

Test Plan:
- Reset then idle 5 cycles -> CtrlState=00, all enables 1, flushes 0, all counters 0.
- ExValid=1, ExMemRead=1, ExRd=3, DecUseRn=1, DecRn=3 -> that cycle PCWrite=0, IFIDWrite=0, IDEXFlush=1; next cycle CtrlState=01, enables 1; then RUN; StallCount=1.
- Same as previous but ExRd=DecRn=31 -> no stall, StallCount stays 0.
- MemReq=1 with MemAck low 3 cycles, then high -> all enables 0 for 4 cycles (1 in RUN + 3 in MEM_WAIT), enables 1 on the MemAck cycle; StallCount=4; then RUN.
- MemBrTaken=1 together with LU=1 and MemReq=1 -> only the three flushes asserted, enables 1, FlushCount=1, state RUN.
- MEM_TIMEOUT=4, MemReq held, MemAck never asserted -> MemTimeout=1 after 4 MEM_WAIT cycles, state RUN, flag stays set until reset=0.
